// File: rtl/led_pkg.sv
// Shared mode encoding and helpers for the LED pattern generator.
package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    OFF   = 2'd0,
    ON    = 2'd1,
    BLINK = 2'd2,
    PWM   = 2'd3
  } mode_t;

  // Static modes have no pattern to finish, so new config applies at once.
  function automatic logic is_static(mode_t m);
    return (m == OFF) || (m == ON);
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Channel configuration write port for the LED pattern generator.
interface led_pattern_gen_if import led_pkg::*; #(
  parameter int CNT_W = 16
);

  logic              cfg_we;
  logic [3:0]        cfg_ch;
  logic [MODE_W-1:0] cfg_mode;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_duty;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_mode,
    output cfg_period,
    output cfg_duty
  );

  modport slave (
    input cfg_we,
    input cfg_ch,
    input cfg_mode,
    input cfg_period,
    input cfg_duty
  );

endinterface

// File: rtl/led_channel.sv
// One LED channel: shadow/active config, tick counter, pattern decode.
module led_channel import led_pkg::*; #(
  parameter int    CNT_W      = 16,
  parameter mode_t DEF_MODE   = BLINK,
  parameter int    DEF_PERIOD = 500,
  parameter bit    ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             we,
  input  mode_t            wr_mode,
  input  logic [CNT_W-1:0] wr_period,
  input  logic [CNT_W-1:0] wr_duty,
  output logic             led
);

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] RST_DUTY   = CNT_W'(DEF_PERIOD / 2);

  mode_t            act_mode;
  mode_t            shd_mode;
  mode_t            nxt_mode;
  logic [CNT_W-1:0] act_period;
  logic [CNT_W-1:0] act_duty;
  logic [CNT_W-1:0] shd_period;
  logic [CNT_W-1:0] shd_duty;
  logic [CNT_W-1:0] nxt_period;
  logic [CNT_W-1:0] nxt_duty;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] eff_period;
  logic [CNT_W-1:0] half;
  logic             wrap;
  logic             commit;
  logic             on;

  always_comb begin
    eff_period = (act_period == '0) ? CNT_W'(1) : act_period;
    half       = eff_period >> 1;
    wrap       = tick && (cnt >= eff_period - CNT_W'(1));
    commit     = wrap || (we && is_static(act_mode));
    // A write in the commit cycle bypasses the shadow so it is never lost.
    nxt_mode   = we ? wr_mode   : shd_mode;
    nxt_period = we ? wr_period : shd_period;
    nxt_duty   = we ? wr_duty   : shd_duty;
  end

  always_comb begin
    on = 1'b0;
    unique case (1'b1)
      act_mode == OFF:   on = 1'b0;
      act_mode == ON:    on = 1'b1;
      act_mode == BLINK: on = cnt < half;
      default:           on = cnt < act_duty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      act_mode   <= DEF_MODE;
      act_period <= RST_PERIOD;
      act_duty   <= RST_DUTY;
      shd_mode   <= DEF_MODE;
      shd_period <= RST_PERIOD;
      shd_duty   <= RST_DUTY;
      cnt        <= '0;
      led        <= ACTIVE_LOW;
    end else begin
      if (we) begin
        shd_mode   <= wr_mode;
        shd_period <= wr_period;
        shd_duty   <= wr_duty;
      end
      if (commit) begin
        act_mode   <= nxt_mode;
        act_period <= nxt_period;
        act_duty   <= nxt_duty;
        cnt        <= '0;
      end else if (tick) begin
        cnt <= cnt + CNT_W'(1);
      end
      led <= on ^ ACTIVE_LOW;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: tick prescaler plus N_CH channels.
module led_pattern_gen import led_pkg::*; #(
  parameter int    N_CH       = 2,
  parameter int    CLK_HZ     = 1000000,
  parameter int    TICK_HZ    = 1000,
  parameter int    CNT_W      = 16,
  parameter mode_t DEF_MODE   = BLINK,
  parameter int    DEF_PERIOD = 500,
  parameter bit    ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  led_pattern_gen_if.slave    cfg,
  output logic [N_CH-1:0]     o_LED,
  output logic                o_tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
    $error("CLK_HZ/TICK_HZ must be an integer >= 2");
  end
  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("N_CH must be in 1..16");
  end

  logic [PW-1:0] presc;

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (presc == PW'(DIV - 1)) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign o_tick = (presc == PW'(DIV - 1));

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic hit;

    // Channels beyond N_CH have no decode, so such writes fall away.
    assign hit = cfg.cfg_we && (cfg.cfg_ch == 4'(g));

    led_channel #(
      .CNT_W      (CNT_W),
      .DEF_MODE   (DEF_MODE),
      .DEF_PERIOD (DEF_PERIOD),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (o_tick),
      .we        (hit),
      .wr_mode   (mode_t'(cfg.cfg_mode)),
      .wr_period (cfg.cfg_period),
      .wr_duty   (cfg.cfg_duty),
      .led       (o_LED[g])
    );
  end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 The block SHALL use parameter N_CH, default 2, as the number of LED channels (1..16).
REQ-002 The block SHALL use parameter CLK_HZ, default 1000000, as the input clock frequency.
REQ-003 The block SHALL use parameter TICK_HZ, default 1000, as the pattern tick rate; CLK_HZ/TICK_HZ SHALL be an integer >= 2.
REQ-004 The block SHALL use parameter CNT_W, default 16, as the period/duty width.
REQ-005 The block SHALL use parameter DEF_MODE, default BLINK, as the mode of every channel after reset.
REQ-006 The block SHALL use parameter DEF_PERIOD, default 500, as the period of every channel after reset.
REQ-007 The block SHALL use parameter ACTIVE_LOW, default 0; when 1, every o_LED bit is inverted at the output.
REQ-008 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-009 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 Port cfg_we, input, 1 bit: config write strobe.
REQ-011 Port cfg_ch, input, 4 bits: target channel.
REQ-012 Port cfg_mode, input, 2 bits: OFF=0, ON=1, BLINK=2, PWM=3.
REQ-013 Port cfg_period, input, CNT_W bits: period in ticks.
REQ-014 Port cfg_duty, input, CNT_W bits: on-time in ticks.
REQ-015 Port o_LED, output, N_CH bits: LED drive, registered.
REQ-016 Port o_tick, output, 1 bit: one-clk pulse per tick.

Function
REQ-017 Prescaler SHALL count 0..CLK_HZ/TICK_HZ-1 and assert o_tick for exactly one clk on the terminal count.
REQ-018 Each channel SHALL hold active {mode, period, duty} and shadow {mode, period, duty} registers.
REQ-019 A cfg_we with cfg_ch < N_CH SHALL load that channel's shadow; cfg_ch >= N_CH SHALL be ignored with no side effect.
REQ-020 Each channel counter SHALL advance on o_tick only, counting 0..period-1, then wrapping to 0.
REQ-021 A period of 0 SHALL be treated as 1.
REQ-022 Shadow SHALL be copied to active, and the counter zeroed, on the tick that wraps the counter; if active mode is OFF or ON, the copy SHALL occur on the clk after the write.
REQ-023 A write coinciding with a commit cycle SHALL be committed in that same cycle (write-through), never lost.
REQ-024 OFF: the LED SHALL be 0.
REQ-025 ON: the LED SHALL be 1.
REQ-026 BLINK: the LED SHALL be 1 while counter < period/2 (floor); this is 0 for period 1.
REQ-027 PWM: the LED SHALL be 1 while counter < duty; duty=0 gives constant 0, duty >= period gives constant 1.
REQ-028 o_LED SHALL update one clk after the counter or active state change (1-cycle registered latency).
REQ-029 Channels SHALL be mutually independent; a write to one channel SHALL NOT disturb another channel's counter.

Reset
REQ-030 On reset: prescaler=0, o_tick=0, all counters=0.
REQ-031 On reset: active and shadow registers = {DEF_MODE, DEF_PERIOD, DEF_PERIOD/2}.
REQ-032 On reset: o_LED = ACTIVE_LOW ? all-ones : all-zeros for one clk, then follows mode.
REQ-033 Reset mid-period SHALL abandon pending shadow writes.

Structure
REQ-034 Package led_pkg SHALL hold the mode encoding (OFF/ON/BLINK/PWM) and the constant MODE_W=2.
REQ-035 Per-channel logic SHALL be sub-module led_channel, instantiated N_CH times; the prescaler SHALL stay in the top.

Verification (CLK_HZ=1000, TICK_HZ=100, N_CH=2, DEF_PERIOD=4)
REQ-036 Reset release -> o_tick pulses every 10 clk; both LEDs BLINK at 2 ticks on, 2 ticks off.
REQ-037 Write ch0 PWM period=5 duty=1 mid-period -> the old pattern finishes to the wrap, then 1 tick on, 4 ticks off; ch1 unchanged.
REQ-038 Write ch1 ON while in OFF -> o_LED[1]=1 two clk after cfg_we (one clk commit, one clk output register).
REQ-039 PWM duty=0 -> constant 0; duty=7, period=5 -> constant 1; period=0 in BLINK -> constant 0.
REQ-040 cfg_ch=5 write -> no change; write landing on the wrap tick -> the new value is active from that tick.
REQ-041 Assert reset mid-blink with a pending shadow -> defaults are restored and the pending write is discarded; ACTIVE_LOW=1 build shows inverted o_LED.
